// File: rtl/race_pkg.sv
// Shared types and constants for the racing game's crash logic.
package race_pkg;

    // Game state machine encoding.
    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_CRASH     = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    // Visible screen geometry.
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Last visible pixel of a frame.
    localparam logic [9:0] LAST_COL = 10'(SCREEN_W - 1);
    localparam logic [9:0] LAST_ROW = 10'(SCREEN_H - 1);

    // Overlay colour meaning "no car at this pixel".
    localparam logic [11:0] BLACK = 12'h000;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

endpackage

// File: rtl/overlap_counter.sv
// Counts player/traffic overlap pixels per frame and flags the last pixel.
// Inputs are the pixel-aligned (already delayed) coordinates plus overlays.
// Evaluation is held off until a full frame has started (visible pixel 0,0)
// so a reset partway through a frame never produces a bogus count.
module overlap_counter
    import race_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic [9:0]  row_i,
    input  logic [9:0]  col_i,
    input  logic        von_i,
    input  logic [11:0] car_i,
    input  logic [11:0] player_i,
    output logic        frame_end_o,
    output logic [7:0]  count_o
);

    logic [7:0] count_q, count_d;
    logic       armed_q, armed_d;
    logic       hit;
    logic       last_pix;

    // Overlap test, running count including this pixel, and frame sync.
    always_comb begin
        hit      = von_i && (car_i != BLACK) && (player_i != BLACK);
        last_pix = (row_i == LAST_ROW) && (col_i == LAST_COL);
        count_o  = hit ? sat_inc8(count_q) : count_q;
        armed_d  = armed_q | (von_i && (row_i == 10'd0) && (col_i == 10'd0));
        // Counter restarts after the frame's last pixel or when told to drop it.
        count_d  = (last_pix || clear_i) ? 8'd0 : count_o;
        frame_end_o = armed_q && last_pix;
    end

    // Count and sync registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
            armed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/crash_monitor.sv
// Crash detection, lives/high-score bookkeeping and crash flashing.
// Optional feature macro: CRASH_FLASH_EN enables flash_blank during CRASH.
module crash_monitor
    import race_pkg::*;
#(
    parameter int unsigned OVERLAP_MIN  = 4,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned FLASH_FRAMES = 60
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pix_row,
    input  logic [9:0]  pix_col,
    input  logic        video_on,
    input  logic [11:0] moving_cars_in,
    input  logic [11:0] player_car_in,
    input  logic [5:0]  score_in,
    input  logic        restart_btn,
    output logic        crash_pulse,
    output logic [1:0]  lives_out,
    output logic        game_over,
    output logic        freeze,
    output logic [5:0]  high_score_out,
    output logic        flash_blank
);

    state_t      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  frames_q, frames_d;
    logic [5:0]  high_q, high_d;
    logic        pulse_q, pulse_d;
    logic        btn_q, btn_d;
    logic [9:0]  row_q, row_d;
    logic [9:0]  col_q, col_d;
    logic        von_q, von_d;

    logic        frame_end;
    logic [7:0]  count;
    logic        restart_rise;
    logic        restart_take;
    logic [1:0]  lives_dec;

    overlap_counter u_ovl (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (restart_take),
        .row_i       (row_q),
        .col_i       (col_q),
        .von_i       (von_q),
        .car_i       (moving_cars_in),
        .player_i    (player_car_in),
        .frame_end_o (frame_end),
        .count_o     (count)
    );

    // Timing pipe so coordinates line up with the registered overlays.
    always_comb begin
        row_d = pix_row;
        col_d = pix_col;
        von_d = video_on;
        btn_d = restart_btn;
    end

    // Restart is only honoured from GAME_OVER; the frame it lands in is dropped.
    assign restart_rise = restart_btn && !btn_q;
    assign restart_take = (state_q == ST_GAME_OVER) && restart_rise;

    // Next-state and bookkeeping logic.
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        frames_d  = frames_q;
        high_d    = high_q;
        pulse_d   = 1'b0;
        lives_dec = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        case (state_q)
            ST_PLAY: begin
                if (frame_end && (32'(count) >= OVERLAP_MIN)) begin
                    pulse_d = 1'b1;
                    lives_d = lives_dec;
                    if (lives_dec == 2'd0) begin
                        state_d = ST_GAME_OVER;
                        if (score_in > high_q) high_d = score_in;
                    end else begin
                        state_d  = ST_CRASH;
                        frames_d = 8'(FLASH_FRAMES);
                    end
                end
            end
            ST_CRASH: begin
                if (frame_end) begin
                    if (frames_q <= 8'd1) begin
                        frames_d = 8'd0;
                        state_d  = ST_PLAY;
                    end else begin
                        frames_d = frames_q - 8'd1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (restart_take) begin
                    state_d = ST_PLAY;
                    lives_d = 2'(LIVES_INIT);
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_PLAY;
            lives_q  <= 2'(LIVES_INIT);
            frames_q <= 8'd0;
            high_q   <= 6'd0;
            pulse_q  <= 1'b0;
            btn_q    <= 1'b0;
            row_q    <= 10'd0;
            col_q    <= 10'd0;
            von_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            frames_q <= frames_d;
            high_q   <= high_d;
            pulse_q  <= pulse_d;
            btn_q    <= btn_d;
            row_q    <= row_d;
            col_q    <= col_d;
            von_q    <= von_d;
        end
    end

    assign crash_pulse    = pulse_q;
    assign lives_out      = lives_q;
    assign game_over      = (state_q == ST_GAME_OVER);
    assign freeze         = (state_q != ST_PLAY);
    assign high_score_out = high_q;

`ifdef CRASH_FLASH_EN
    // Blink in 8-frame phases while the crash countdown runs.
    assign flash_blank = (state_q == ST_CRASH) && frames_q[3];
`else
    assign flash_blank = 1'b0;
`endif

endmodule

// File: tb/tb_crash_monitor.sv
// Self-checking bench for crash_monitor (default parameters).
// The bench acts as the timing generator: it only walks the pixels that
// matter in each frame and presents overlays one cycle after coordinates.
module tb_crash_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pix_row, pix_col;
    logic        video_on;
    logic [11:0] moving_cars_in, player_car_in;
    logic [5:0]  score_in;
    logic        restart_btn;
    logic        crash_pulse;
    logic [1:0]  lives_out;
    logic        game_over, freeze;
    logic [5:0]  high_score_out;
    logic        flash_blank;

    crash_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .pix_row        (pix_row),
        .pix_col        (pix_col),
        .video_on       (video_on),
        .moving_cars_in (moving_cars_in),
        .player_car_in  (player_car_in),
        .score_in       (score_in),
        .restart_btn    (restart_btn),
        .crash_pulse    (crash_pulse),
        .lives_out      (lives_out),
        .game_over      (game_over),
        .freeze         (freeze),
        .high_score_out (high_score_out),
        .flash_blank    (flash_blank)
    );

    always #5 clk = ~clk;

    // One frame of stimulus and what must follow it.
    typedef struct {
        int nh;   // overlapping visible pixels before the last pixel
        int hl;   // last pixel (479,639) overlaps too
        int nv;   // overlapping pixels with video_on low
        int rb;   // restart_btn rises on the frame-end cycle
        int sc;   // score_in for this frame
        int ep;   // expected crash_pulse
        int el;   // expected lives
        int ef;   // expected freeze
        int eg;   // expected game_over
        int ehs;  // expected high score
        int cp;   // follow with a full crash countdown
    } vec_t;

    vec_t vecs[11];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   prev_hit = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present one pixel; overlays belong to the pixel of the previous call.
    task automatic step(input int r, input int c, input int v, input int h);
        moving_cars_in = 12'hF00;
        player_car_in  = (prev_hit != 0) ? 12'h0F0 : 12'h000;
        pix_row  = 10'(r);
        pix_col  = 10'(c);
        video_on = (v != 0);
        prev_hit = h;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pulse"}, crash_pulse, 0);
        check({tag, "_lives"}, lives_out, 3);
        check({tag, "_go"},    game_over, 0);
        check({tag, "_freeze"}, freeze, 0);
        check({tag, "_hs"},    high_score_out, 0);
        check({tag, "_flash"}, flash_blank, 0);
    endtask

    task automatic do_frame(input vec_t v);
        vec_t e;
        score_in = 6'(v.sc);
        sb.push_back(v);
        step(0, 0, 1, 0);
        for (int i = 0; i < v.nh; i++) step(10, i, 1, 1);
        for (int i = 0; i < v.nv; i++) step(11, i, 0, 1);
        step(479, 639, 1, v.hl);
        restart_btn = (v.rb != 0);
        step(300, 0, 0, 0);          // aligned frame-end cycle clocks here
        restart_btn = 1'b0;
        e = sb.pop_front();
        check("pulse", crash_pulse, e.ep);
        check("lives", lives_out, e.el);
        check("freeze", freeze, e.ef);
        check("game_over", game_over, e.eg);
        check("high_score", high_score_out, e.ehs);
        step(300, 1, 0, 0);
        check("pulse_width", crash_pulse, 0);
    endtask

    // Sixty overlapping frames while frozen: no crash, flash follows countdown.
    task automatic crash_period(input int lives, input int hs);
        vec_t v;
        int   fc;
        int   ef;
        for (int k = 1; k <= 60; k++) begin
            v = '{10, 1, 0, 0, int'(score_in), 0, lives, (k < 60) ? 1 : 0, 0, hs, 0};
            do_frame(v);
            fc = 60 - k;
`ifdef CRASH_FLASH_EN
            ef = (k < 60) ? ((fc >> 3) & 1) : 0;
`else
            ef = 0;
`endif
            check("flash_blank", flash_blank, ef);
        end
    endtask

    initial begin
        //          nh hl nv rb sc  ep el ef eg ehs cp
        vecs[0]  = '{2, 1, 0, 0, 0,  0, 3, 0, 0, 0,  0}; // 3 overlaps incl. last: below min
        vecs[1]  = '{0, 0, 10,0, 0,  0, 3, 0, 0, 0,  0}; // overlap off-screen ignored
        vecs[2]  = '{0, 0, 0, 1, 0,  0, 3, 0, 0, 0,  0}; // restart ignored in PLAY
        vecs[3]  = '{3, 1, 0, 0, 0,  1, 2, 1, 0, 0,  1}; // exactly 4, last pixel counted
        vecs[4]  = '{10,0, 0, 0, 0,  1, 1, 1, 0, 0,  1};
        vecs[5]  = '{10,0, 0, 0, 17, 1, 0, 1, 1, 17, 0}; // third crash -> game over
        vecs[6]  = '{10,1, 0, 0, 17, 0, 0, 1, 1, 17, 0}; // no wrap below 0
        vecs[7]  = '{10,1, 0, 1, 17, 0, 3, 0, 0, 17, 0}; // restart on frame end wins
        vecs[8]  = '{10,0, 0, 0, 12, 1, 2, 1, 0, 17, 1};
        vecs[9]  = '{10,0, 0, 0, 12, 1, 1, 1, 0, 17, 1};
        vecs[10] = '{10,0, 0, 0, 12, 1, 0, 1, 1, 17, 0}; // lower score keeps 17

        reset = 1'b1;
        restart_btn = 1'b0;
        score_in = 6'd0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        check_reset_vals("rst");
        reset = 1'b0;
        step(300, 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            do_frame(vecs[i]);
            if (vecs[i].cp != 0) crash_period(vecs[i].el, vecs[i].ehs);
        end

        // Back to PLAY, crash once, then reset partway through a frame.
        do_frame('{0, 0, 0, 1, 5, 0, 3, 0, 0, 17, 0});
        do_frame('{10, 0, 0, 0, 5, 1, 2, 1, 0, 17, 0});
        step(0, 0, 1, 0);
        for (int i = 0; i < 50; i++) step(200, i, 1, 1);
        reset = 1'b1;
        step(200, 50, 1, 1);
        check_reset_vals("midrst");
        reset = 1'b0;
        for (int i = 51; i < 61; i++) step(200, i, 1, 1);
        step(479, 639, 1, 1);
        step(300, 0, 0, 0);
        check("partial_pulse", crash_pulse, 0);
        check("partial_lives", lives_out, 3);
        check("partial_freeze", freeze, 0);
        do_frame('{0, 0, 0, 0, 5, 0, 3, 0, 0, 0, 0});   // clean frame
        do_frame('{10, 0, 0, 0, 5, 1, 2, 1, 0, 0, 0});  // detection resumed

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
